// File: rtl/cps_sram_pkg.sv
// Shared definitions for the CPS video-RAM SRAM controller.
//   PH_P1..PH_P4 : bit index of each phase inside the one-hot ram_cyc vector
//   CH_W         : width of a channel id / SLOT_MAP field
//   slot_owner() : extracts the owner channel of one slot from a SLOT_MAP word
package cps_sram_pkg;

   localparam int PH_P1 = 0;
   localparam int PH_P2 = 1;
   localparam int PH_P3 = 2;
   localparam int PH_P4 = 3;

   localparam int CH_W = 2;

   // Slot 0 lives in the LSBs of the map.
   function automatic logic [CH_W-1:0] slot_owner(input logic [31:0] map, input int slot);
      return map[slot*CH_W +: CH_W];
   endfunction

endpackage

// File: rtl/cps_sram_slot_sel.sv
// Combinational grant selection for one ram_acc slot.
//   slot    : one-hot ram_acc; zero or multi-hot means "no valid slot"
//   req     : per-channel request lines
//   ram_ref : SDRAM refresh, suppresses any grant
//   grant   : a channel is granted this slot
//   id      : granted channel (valid with grant)
// The static owner always wins; otherwise, with DONATE set, the slot goes to
// the lowest-indexed requester. A map entry naming a channel that does not
// exist behaves like an idle owner.
module cps_sram_slot_sel
   import cps_sram_pkg::*;
#(
   parameter int                 NUM_CH   = 3,
   parameter int                 SLOTS    = 4,
   parameter logic [2*SLOTS-1:0] SLOT_MAP = 8'b11_10_01_00,
   parameter bit                 DONATE   = 1'b1
) (
   input  logic [SLOTS-1:0]  slot,
   input  logic [NUM_CH-1:0] req,
   input  logic              ram_ref,
   output logic              grant,
   output logic [CH_W-1:0]   id
);

   localparam logic [31:0] MAP32 = 32'(SLOT_MAP);

   int unsigned     hot_cnt;
   logic [CH_W-1:0] owner;
   logic            owner_req;
   logic [CH_W-1:0] low_id;

   always_comb begin
      hot_cnt   = 0;
      owner     = '0;
      owner_req = 1'b0;
      low_id    = '0;
      grant     = 1'b0;
      id        = '0;
      for (int s = 0; s < SLOTS; s++) begin
         if (slot[s]) begin
            hot_cnt = hot_cnt + 1;
            owner   = slot_owner(MAP32, s);
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (owner == CH_W'(c) && req[c]) owner_req = 1'b1;
      end
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (req[c]) low_id = CH_W'(c);
      end
      if (!ram_ref && hot_cnt == 1) begin
         if (owner_req) begin
            grant = 1'b1;
            id    = owner;
         end else if (DONATE && (|req)) begin
            grant = 1'b1;
            id    = low_id;
         end
      end
   end

endmodule

// File: rtl/cps_sram_mc_ctrl.sv
// Multi-channel asynchronous SRAM controller driven by the SDRAM slot schedule.
// Each ram_acc slot runs a fixed 4-phase access: P1 latch, P2 strobe,
// P3 capture, P4 return.
//   bus_clk/bus_rst           : clock, asynchronous active-high reset
//   ram_ref/ram_cyc/ram_acc   : refresh flag, one-hot phase, one-hot slot
//   ch_req/we/be/addr/wdata   : per-channel request and payload
//   ch_ack/ch_rvalid/ch_rdata : grant pulse, read-valid pulse, shared read data
//   sram_*                    : SRAM pins (active-low strobes, word address, data)
// Handshake: a requester raises ch_req with its payload and holds both until
// ch_ack pulses; it must then drop req or present the next request before the
// following P1. Read data arrives later on ch_rvalid, 3 cycles after ch_ack.
module cps_sram_mc_ctrl
   import cps_sram_pkg::*;
#(
   parameter int                 NUM_CH   = 3,
   parameter int                 SLOTS    = 4,
   parameter int                 ADDR_W   = 20,
   parameter logic [2*SLOTS-1:0] SLOT_MAP = 8'b11_10_01_00,
   parameter bit                 DONATE   = 1'b1
) (
   input  logic                     bus_rst,
   input  logic                     bus_clk,
   input  logic                     ram_ref,
   input  logic [3:0]               ram_cyc,
   input  logic [SLOTS-1:0]         ram_acc,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_we,
   input  logic [4*NUM_CH-1:0]      ch_be,
   input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
   input  logic [32*NUM_CH-1:0]     ch_wdata,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH-1:0]        ch_rvalid,
   output logic [31:0]              ch_rdata,
   output logic                     sram_ce_n,
   output logic                     sram_oe_n,
   output logic                     sram_we_n,
   output logic [3:0]               sram_be_n,
   output logic [ADDR_W-3:0]        sram_addr,
   output logic                     sram_dq_oe,
   output logic [31:0]              sram_dq_o,
   input  logic [31:0]              sram_dq_i
);

   logic            g_grant;
   logic [CH_W-1:0] g_id;

   cps_sram_slot_sel #(
      .NUM_CH   (NUM_CH),
      .SLOTS    (SLOTS),
      .SLOT_MAP (SLOT_MAP),
      .DONATE   (DONATE)
   ) u_slot_sel (
      .slot    (ram_acc),
      .req     (ch_req),
      .ram_ref (ram_ref),
      .grant   (g_grant),
      .id      (g_id)
   );

   // Payload of the channel picked for this slot.
   logic              sel_we;
   logic [3:0]        sel_be;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;

   always_comb begin
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (g_id == CH_W'(c)) begin
            sel_we    = ch_we[c];
            sel_be    = ch_be[c*4 +: 4];
            sel_addr  = ch_addr[c*ADDR_W +: ADDR_W];
            sel_wdata = ch_wdata[c*32 +: 32];
         end
      end
   end

   // Byte-offset bits never reach the 32-bit SRAM.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^sel_addr[1:0];

   logic              lat_rd, lat_wr;
   logic [3:0]        lat_be;
   logic [ADDR_W-3:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [CH_W-1:0]   lat_id;
   logic [31:0]       cap_q;

   // P1 latch: rd/wr clear on an empty slot, address and data simply hold.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_be    <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_id    <= '0;
         ch_ack    <= '0;
      end else begin
         ch_ack <= '0;
         if (ram_cyc[PH_P1]) begin
            if (g_grant) begin
               lat_rd    <= ~sel_we;
               lat_wr    <= sel_we;
               lat_be    <= sel_be;
               lat_addr  <= sel_addr[ADDR_W-1:2];
               lat_wdata <= sel_wdata;
               lat_id    <= g_id;
               ch_ack    <= NUM_CH'(1) << g_id;
            end else begin
               lat_rd <= 1'b0;
               lat_wr <= 1'b0;
            end
         end
      end
   end

   // Strobes are active only in the single cycle following the P2 edge.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_be_n <= 4'hF;
      end else if (ram_cyc[PH_P2]) begin
         sram_ce_n <= ~((lat_rd | lat_wr) && (lat_be != 4'h0));
         sram_oe_n <= ~lat_rd;
         sram_we_n <= ~lat_wr;
         sram_be_n <= (lat_rd | lat_wr) ? ~lat_be : 4'hF;
      end else begin
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_be_n <= 4'hF;
      end
   end

   // Free-running capture; at P4 it holds the data seen during the strobe cycle.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         cap_q     <= '0;
         ch_rdata  <= '0;
         ch_rvalid <= '0;
      end else begin
         cap_q     <= sram_dq_i;
         ch_rvalid <= '0;
         if (ram_cyc[PH_P4] && lat_rd) begin
            ch_rdata  <= cap_q;
            ch_rvalid <= NUM_CH'(1) << lat_id;
         end
      end
   end

   assign sram_addr  = lat_addr;
   assign sram_dq_o  = lat_wdata;
   assign sram_dq_oe = lat_wr;

endmodule

// File: tb/tb_cps_sram_mc_ctrl.sv
// Self-checking bench for cps_sram_mc_ctrl. Stimulus drives the slot
// schedule phase by phase and pushes expected ack/rvalid events into exp_q;
// a negedge monitor pops and compares whenever the DUT pulses ch_ack or
// ch_rvalid. Pin-level strobe values are compared inline by the stimulus.
// A second instance with DONATE = 0 shares the inputs.
module tb_cps_sram_mc_ctrl;

   localparam int NUM_CH = 3;
   localparam int SLOTS  = 4;
   localparam int ADDR_W = 20;
   localparam int W      = 36;   // {kind[1:0], ch[1:0], data[31:0]}

   localparam logic [1:0] K_ACK = 2'd0;
   localparam logic [1:0] K_RD  = 2'd1;   // rvalid with data check
   localparam logic [1:0] K_RDX = 2'd2;   // rvalid, data don't-care

   logic                     bus_rst, bus_clk;
   logic                     ram_ref;
   logic [3:0]               ram_cyc;
   logic [SLOTS-1:0]         ram_acc;
   logic [NUM_CH-1:0]        ch_req, ch_we;
   logic [4*NUM_CH-1:0]      ch_be;
   logic [ADDR_W*NUM_CH-1:0] ch_addr;
   logic [32*NUM_CH-1:0]     ch_wdata;
   logic [NUM_CH-1:0]        ch_ack, ch_rvalid;
   logic [31:0]              ch_rdata;
   logic                     sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
   logic [3:0]               sram_be_n;
   logic [ADDR_W-3:0]        sram_addr;
   logic [31:0]              sram_dq_o, sram_dq_i;

   logic [NUM_CH-1:0]        nd_ch_ack, nd_ch_rvalid;
   logic [31:0]              nd_ch_rdata, nd_sram_dq_o;
   logic                     nd_ce_n, nd_oe_n, nd_we_n, nd_dq_oe;
   logic [3:0]               nd_be_n;
   logic [ADDR_W-3:0]        nd_sram_addr;

   cps_sram_mc_ctrl #(.NUM_CH(NUM_CH), .SLOTS(SLOTS), .ADDR_W(ADDR_W),
                      .SLOT_MAP(8'b11_10_01_00), .DONATE(1'b1)) dut (
      .bus_rst(bus_rst), .bus_clk(bus_clk), .ram_ref(ram_ref), .ram_cyc(ram_cyc),
      .ram_acc(ram_acc), .ch_req(ch_req), .ch_we(ch_we), .ch_be(ch_be),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rvalid(ch_rvalid),
      .ch_rdata(ch_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_be_n(sram_be_n), .sram_addr(sram_addr),
      .sram_dq_oe(sram_dq_oe), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i));

   cps_sram_mc_ctrl #(.NUM_CH(NUM_CH), .SLOTS(SLOTS), .ADDR_W(ADDR_W),
                      .SLOT_MAP(8'b11_10_01_00), .DONATE(1'b0)) dut_nd (
      .bus_rst(bus_rst), .bus_clk(bus_clk), .ram_ref(ram_ref), .ram_cyc(ram_cyc),
      .ram_acc(ram_acc), .ch_req(ch_req), .ch_we(ch_we), .ch_be(ch_be),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(nd_ch_ack), .ch_rvalid(nd_ch_rvalid),
      .ch_rdata(nd_ch_rdata), .sram_ce_n(nd_ce_n), .sram_oe_n(nd_oe_n),
      .sram_we_n(nd_we_n), .sram_be_n(nd_be_n), .sram_addr(nd_sram_addr),
      .sram_dq_oe(nd_dq_oe), .sram_dq_o(nd_sram_dq_o), .sram_dq_i(sram_dq_i));

   // ---------------- clock / reset ----------------
   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   int cyc = 0;
   always @(posedge bus_clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_ack(input int c);
      exp_q.push_back({K_ACK, 2'(c), 32'h0});
   endtask
   task automatic push_rd(input int c, input logic [31:0] d);
      exp_q.push_back({K_RD, 2'(c), d});
   endtask
   task automatic push_rdx(input int c);
      exp_q.push_back({K_RDX, 2'(c), 32'h0});
   endtask

   int ack_cyc = 0;

   always @(negedge bus_clk) begin
      logic [W-1:0] e;
      if (!bus_rst) begin
         if (ch_rvalid != '0) begin
            if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(ch_rvalid), 32'h0);
            else begin
               e = exp_q.pop_front();
               chk("rvalid_expected", 32'(e[35:34] != K_ACK), 32'h1);
               chk("rvalid_id", 32'(ch_rvalid), 32'(3'(1) << e[33:32]));
               chk("rvalid_latency", 32'(cyc - ack_cyc), 32'd3);
               if (e[35:34] == K_RD) chk("rvalid_data", ch_rdata, e[31:0]);
            end
         end
         if (ch_ack != '0) begin
            ack_cyc = cyc;
            if (exp_q.size() == 0) chk("ack_unexpected", 32'(ch_ack), 32'h0);
            else begin
               e = exp_q.pop_front();
               chk("ack_expected", 32'(e[35:34]), 32'(K_ACK));
               chk("ack_id", 32'(ch_ack), 32'(3'(1) << e[33:32]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic       s_ce, s_oe, s_we, s_dq_oe, s_p1_dq_oe;
   logic [3:0] s_be;
   logic [ADDR_W-3:0] s_addr;
   logic [31:0] s_dq_o;
   logic [NUM_CH-1:0] s_nd_ack;

   task automatic set_req(input int c, input logic we, input logic [3:0] be,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d);
      ch_req[c] = 1'b1;
      ch_we[c]  = we;
      ch_be[c*4 +: 4] = be;
      ch_addr[c*ADDR_W +: ADDR_W] = a;
      ch_wdata[c*32 +: 32] = d;
   endtask

   // Drive one phase through its active edge; outside the post-P2 cycle the
   // strobes must be idle.
   task automatic phase(input int p);
      ram_cyc = 4'(1 << p);
      @(posedge bus_clk);
      #1;
      if (p != 1) chk("strobes_idle", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
   endtask

   task automatic run_slot(input logic [3:0] acc, input logic refr);
      ram_acc = acc;
      ram_ref = refr;
      phase(0);
      s_nd_ack   = nd_ch_ack;
      s_p1_dq_oe = sram_dq_oe;
      phase(1);
      s_ce = sram_ce_n; s_oe = sram_oe_n; s_we = sram_we_n; s_be = sram_be_n;
      s_addr = sram_addr; s_dq_o = sram_dq_o; s_dq_oe = sram_dq_oe;
      phase(2);
      phase(3);
      ram_ref = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus_rst = 1'b1; ram_ref = 1'b0; ram_cyc = '0; ram_acc = '0;
      ch_req = '0; ch_we = '0; ch_be = '0; ch_addr = '0; ch_wdata = '0;
      sram_dq_i = '0;
      repeat (3) @(posedge bus_clk);
      #1;
      chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}), 32'h7F);
      chk("rst_ack_rvalid", 32'({ch_ack, ch_rvalid}), 32'h0);
      chk("rst_rdata", ch_rdata, 32'h0);
      chk("rst_addr_dq", 32'({sram_addr, sram_dq_oe}), 32'h0);
      chk("rst_dq_o", sram_dq_o, 32'h0);
      bus_rst = 1'b0;

      // CH0 read at 0x10, slot 0
      sram_dq_i = 32'hDEADBEEF;
      set_req(0, 1'b0, 4'hF, 20'h00010, 32'h0);
      push_ack(0); push_rd(0, 32'hDEADBEEF);
      run_slot(4'b0001, 1'b0);
      ch_req[0] = 1'b0;
      chk("rd_strobes", 32'({s_ce, s_oe, s_we, s_be}), 32'h10);
      chk("rd_addr", 32'(s_addr), 32'h4);
      chk("rd_dq_oe", 32'(s_dq_oe), 32'h0);

      // CH1 write, be=1100, slot 1
      set_req(1, 1'b1, 4'b1100, 20'h00024, 32'h12345678);
      push_ack(1);
      run_slot(4'b0010, 1'b0);
      ch_req[1] = 1'b0;
      chk("wr_strobes", 32'({s_ce, s_oe, s_we, s_be}), 32'h23);
      chk("wr_addr", 32'(s_addr), 32'h9);
      chk("wr_dq_oe", 32'(s_dq_oe), 32'h1);
      chk("wr_dq_o", s_dq_o, 32'h12345678);

      // Slot 2 owner idle, CH0 pending: donated (DONATE=1), idle (DONATE=0)
      sram_dq_i = 32'hCAFEF00D;
      set_req(0, 1'b0, 4'hF, 20'h00040, 32'h0);
      push_ack(0); push_rd(0, 32'hCAFEF00D);
      run_slot(4'b0100, 1'b0);
      ch_req[0] = 1'b0;
      chk("don_strobes", 32'({s_ce, s_oe, s_we}), 32'h1);
      chk("don_addr", 32'(s_addr), 32'h10);
      chk("nodon_ack", 32'(s_nd_ack), 32'h0);
      chk("nodon_strobes", 32'({nd_ce_n, nd_oe_n, nd_we_n}), 32'h7);

      // Refresh at P1 of slot 0 with all requesting, then owners / donation
      set_req(0, 1'b0, 4'hF, 20'h00100, 32'h0);
      set_req(1, 1'b0, 4'hF, 20'h00104, 32'h0);
      set_req(2, 1'b0, 4'hF, 20'h00108, 32'h0);
      run_slot(4'b0001, 1'b1);
      chk("ref_strobes", 32'({s_ce, s_oe, s_we}), 32'h7);
      sram_dq_i = 32'hA5A50001;
      push_ack(1); push_rd(1, 32'hA5A50001);
      run_slot(4'b0010, 1'b0);
      ch_req[1] = 1'b0;
      chk("ref_next_addr", 32'(s_addr), 32'h41);
      sram_dq_i = 32'hA5A50002;
      push_ack(2); push_rd(2, 32'hA5A50002);
      run_slot(4'b0100, 1'b0);
      ch_req[2] = 1'b0;
      sram_dq_i = 32'hA5A50003;
      push_ack(0); push_rd(0, 32'hA5A50003);
      run_slot(4'b1000, 1'b0);   // owner 3 absent: lowest pending gets it
      ch_req[0] = 1'b0;
      chk("slot3_addr", 32'(s_addr), 32'h40);

      // Reset between P2 and P4 of a CH2 read
      sram_dq_i = 32'h55AA55AA;
      set_req(2, 1'b0, 4'hF, 20'h00200, 32'h0);
      push_ack(2);
      ram_acc = 4'b0100;
      phase(0);
      phase(1);
      chk("mid_strobe_on", 32'({sram_ce_n, sram_oe_n}), 32'h0);
      bus_rst = 1'b1;
      #1;
      chk("mid_rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}), 32'h7F);
      chk("mid_rst_addr", 32'({sram_addr, sram_dq_oe, ch_ack}), 32'h0);
      phase(2);
      phase(3);
      chk("mid_rst_rvalid", 32'(ch_rvalid), 32'h0);
      bus_rst = 1'b0;
      push_ack(2); push_rd(2, 32'h55AA55AA);
      run_slot(4'b0001, 1'b0);   // owner CH0 idle, held CH2 re-granted
      ch_req[2] = 1'b0;
      chk("regrant_addr", 32'(s_addr), 32'h80);

      // Invalid ram_acc clears latched write
      set_req(0, 1'b1, 4'b0011, 20'h00300, 32'hA1B2C3D4);
      push_ack(0);
      run_slot(4'b0001, 1'b0);
      ch_req[0] = 1'b0;
      chk("wr2_be_n", 32'({s_we, s_be}), 32'hC);
      chk("wr2_dq_oe_held", 32'(sram_dq_oe), 32'h1);
      sram_dq_i = 32'h0BADF00D;
      set_req(1, 1'b0, 4'hF, 20'h00310, 32'h0);
      run_slot(4'b0000, 1'b0);
      chk("acc0_dq_oe", 32'(s_p1_dq_oe), 32'h0);
      chk("acc0_strobes", 32'({s_ce, s_oe, s_we}), 32'h7);
      run_slot(4'b0011, 1'b0);
      chk("acc3_strobes", 32'({s_ce, s_oe, s_we}), 32'h7);
      push_ack(1); push_rd(1, 32'h0BADF00D);
      run_slot(4'b0010, 1'b0);
      ch_req[1] = 1'b0;

      // Read with be == 0: acked, rvalid, but no chip enable
      set_req(0, 1'b0, 4'h0, 20'h00400, 32'h0);
      push_ack(0); push_rdx(0);
      run_slot(4'b0001, 1'b0);
      ch_req[0] = 1'b0;
      chk("be0_strobes", 32'({s_ce, s_oe, s_we, s_be}), 32'h5F);

      ram_cyc = '0;
      repeat (3) @(posedge bus_clk);
      #1;
      chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cps_sram_mc_ctrl.md
# cps_sram_mc_ctrl

Parametrised multi-channel asynchronous SRAM controller for the CPS video-RAM path. It serves NUM_CH requesters with a req/ack handshake. The SDRAM controller's slot schedule (ram_cyc phases, ram_acc slots) drives a fixed 4-phase SRAM access: latch, strobe, capture, return. Each slot has a statically mapped owner. Optionally, an idle owner's slot is donated to another pending channel. The block sits between the 68000/GPU/DMA bus adapters and the 32-bit SRAM pins.

## Interface
Parameters:
- NUM_CH, 3: number of requesting channels (1..4).
- SLOTS, 4: number of ram_acc slots.
- ADDR_W, 20: byte address width.
- SLOT_MAP, 8'b11_10_01_00: 2 bits per slot giving the owner channel. Slot 0 is in the LSBs.
- DONATE, 1: 1 hands an unused slot to the lowest-indexed pending channel; 0 leaves it idle.

Ports (reset bus_rst, asynchronous, active-high; clock bus_clk):
- bus_rst  in  1  asynchronous active-high reset
- bus_clk  in  1  bus clock
- ram_ref  in  1  SDRAM refresh; no SRAM access is started while it is high at P1
- ram_cyc  in  4  one-hot phase P1..P4
- ram_acc  in  SLOTS  one-hot current slot, stable through P1..P4
- ch_req  in  NUM_CH  request; held with payload until ack
- ch_we  in  NUM_CH  1 = write
- ch_be  in  4*NUM_CH  byte enables; bit 3 = bits 31:24 (big endian)
- ch_addr  in  ADDR_W*NUM_CH  byte address; bits 1:0 ignored
- ch_wdata  in  32*NUM_CH  write data
- ch_ack  out  NUM_CH  one-cycle grant pulse
- ch_rvalid  out  NUM_CH  one-cycle read-data-valid pulse
- ch_rdata  out  32  shared read data; qualified by ch_rvalid
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes
- sram_be_n  out  4  SRAM byte enables
- sram_addr  out  ADDR_W-2  word address
- sram_dq_oe  out  1  data-bus drive enable
- sram_dq_o  out  32  write data
- sram_dq_i  in  32  read data

## Operation
- P1 edge (ram_cyc[0]): owner = SLOT_MAP[slot]. Grant rules, in order:
  - ram_ref high, or ram_acc zero or multi-hot: no grant.
  - ch_req[owner] high: grant the owner.
  - Otherwise, if DONATE is 1 and any ch_req is high: grant the lowest-indexed requester.
  - Otherwise: idle.
- On a grant: latch addr, be, we, wdata and the grant id; pulse ch_ack[id] high for 1 cycle.
- On no grant: latched rd/wr are cleared; addr and wdata hold.
- P2 edge: strobes go active for exactly one cycle:
  - ce_n = 0 if (rd or wr) and be != 0.
  - oe_n = ~rd; we_n = ~wr; be_n = ~be.
  - All strobe outputs are inactive on every other cycle.
- sram_addr and sram_dq_o come directly from the P1 latch. sram_dq_oe = latched wr, held until the next P1.
- Every cycle, sram_dq_i is registered into the capture register.
- P4 edge, for a read grant: ch_rdata <= capture register; ch_rvalid[id] = 1 for one cycle.
- A read with be == 0 is still acked and returns rvalid. Its data is don't-care.
- A write never produces rvalid.
- Requester rule: after seeing ack, present the next request or drop req before the next P1. Keeping req high means back-to-back service in a later slot.

## Timing
- Reset values:
  - ch_ack = 0, ch_rvalid = 0, ch_rdata = 0.
  - sram_ce_n/oe_n/we_n = 1, sram_be_n = 4'hF.
  - sram_dq_oe = 0, sram_addr = 0, sram_dq_o = 0.
- Latency:
  - ack is visible 1 cycle after the P1 edge.
  - Strobes are low in the cycle after the P2 edge.
  - rvalid is high in the cycle after the P4 edge, i.e. 3 bus_clk after ack.
- Reset mid-access: all strobes deassert immediately and the in-flight grant is discarded with no rvalid. A still-held req is re-granted after reset.
- Simultaneous requests: the owner always wins its own slot. Donation goes to the lowest index only.

## Structure
- Package cps_sram_pkg holds:
  - Phase indices PH_P1..PH_P4.
  - CH_W = 2.
  - A function to extract a SLOT_MAP field.
- Sub-module cps_sram_slot_sel: combinational grant selection from (slot, req, ram_ref, DONATE) to (grant, id).
- Pipeline registers live in the top.

## Test plan
- CH0 read at 0x00010 in slot 0, sram_dq_i = 32'hDEADBEEF:
  - ack[0] pulses; strobes low for 1 cycle.
  - ch_rvalid[0] fires 3 cycles after ack with ch_rdata = DEADBEEF.
- CH1 write, be = 4'b1100, wdata = 32'h12345678, slot 1:
  - we_n low for 1 cycle, be_n = 4'b0011, dq_oe = 1, sram_addr = addr>>2.
  - No rvalid.
- Slot 2 owner idle, CH0 pending, DONATE = 1:
  - CH0 is served in slot 2.
  - With DONATE = 0: no strobes in slot 2, and CH0 waits for slot 0.
- ram_ref high at P1 with all channels requesting:
  - No ack, no strobes.
  - Requests are served in the next slot.
- Reset asserted between P2 and P4 of a read:
  - All outputs return to reset values; no rvalid.
  - The held req is acked in the first valid slot after reset.
- ram_acc = 0 or 4'b0011 at P1:
  - No grant. Latched rd/wr clear, so sram_dq_oe = 0.
